// File: rtl/opora_koef_loader_if.sv
// opora_koef_loader_if: Ethernet byte stream in, coefficient RAM write port and frame status out.
interface opora_koef_loader_if;
    logic        eth_valid;
    logic        eth_sof;
    logic        eth_eof;
    logic [7:0]  eth_data;
    logic        koef_addr_rst;
    logic        koef_en_out;
    logic [15:0] KOEF_OUT;
    logic        load_done;
    logic        load_err;
    logic        koef_ready;
    logic        busy;

    modport master (
        output eth_valid, eth_sof, eth_eof, eth_data,
        input  koef_addr_rst, koef_en_out, KOEF_OUT, load_done, load_err, koef_ready, busy
    );
    modport slave (
        input  eth_valid, eth_sof, eth_eof, eth_data,
        output koef_addr_rst, koef_en_out, KOEF_OUT, load_done, load_err, koef_ready, busy
    );
endinterface

// File: rtl/opora_koef_loader.sv
// opora_koef_loader: parses a header byte plus MULT_N big-endian words into coefficient RAM writes.
// Optional KOEF_CHECKSUM_EN adds a trailing XOR byte over all coefficient bytes.
module opora_koef_loader #(
    parameter int         MULT_N   = 50,
    parameter logic [7:0] HDR_BYTE = 8'hC3
) (
    input  logic                 clke,
    input  logic                 rst_n,
    opora_koef_loader_if.slave   bus
);
    localparam int CW = $clog2(MULT_N + 1);

`ifdef KOEF_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, MSB, LSB, DRAIN, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, MSB, LSB, DRAIN} state_t;
`endif

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [7:0]    r_hi, w_hi;
    logic [15:0]   r_koef, w_koef;
    logic          r_en, r_arst, r_done, r_err, r_ready, r_derr;
    logic          w_en, w_arst, w_done, w_err, w_ready, w_derr;
    logic          w_last;
`ifdef KOEF_CHECKSUM_EN
    logic [7:0]    r_xor, w_xor;
`endif

    assign w_last = r_cnt == CW'(MULT_N - 1);

    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt;
        w_hi    = r_hi;
        w_koef  = r_koef;
        w_en    = 1'b0;
        w_arst  = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_ready = r_ready;
        w_derr  = r_derr;
`ifdef KOEF_CHECKSUM_EN
        w_xor   = r_xor;
`endif
        if (bus.eth_valid && bus.eth_sof) begin
            // A drain that already reported its error does not report the abort again
            w_err = (r_state != IDLE) && !(r_state == DRAIN && r_derr);
            if (bus.eth_data == HDR_BYTE) begin
                w_arst  = 1'b1;
                w_ready = 1'b0;
                w_cnt   = '0;
`ifdef KOEF_CHECKSUM_EN
                w_xor   = '0;
`endif
                w_next  = bus.eth_eof ? IDLE : MSB;
                w_err   = w_err | bus.eth_eof;
            end else begin
                w_next  = bus.eth_eof ? IDLE : DRAIN;
                w_derr  = 1'b0;
            end
        end else if (bus.eth_valid) begin
            case (r_state)
                MSB: begin
                    w_hi   = bus.eth_data;
                    w_next = bus.eth_eof ? IDLE : LSB;
                    w_err  = bus.eth_eof;
                end
                LSB: begin
                    w_en   = 1'b1;
                    w_koef = {r_hi, bus.eth_data};
                    w_cnt  = r_cnt + CW'(1);
`ifdef KOEF_CHECKSUM_EN
                    w_xor  = r_xor ^ r_hi ^ bus.eth_data;
                    w_next = bus.eth_eof ? IDLE : (w_last ? CHK : MSB);
                    w_err  = bus.eth_eof;
`else
                    w_next  = bus.eth_eof ? IDLE : (w_last ? DRAIN : MSB);
                    w_done  = w_last && bus.eth_eof;
                    w_ready = r_ready | w_done;
                    w_err   = w_last ? !bus.eth_eof : bus.eth_eof;
                    w_derr  = w_last ? 1'b1 : r_derr;
`endif
                end
`ifdef KOEF_CHECKSUM_EN
                CHK: begin
                    w_next  = bus.eth_eof ? IDLE : DRAIN;
                    w_done  = bus.eth_eof && (bus.eth_data == r_xor);
                    w_ready = r_ready | w_done;
                    w_err   = !w_done;
                    w_derr  = 1'b1;
                end
`endif
                DRAIN: w_next = bus.eth_eof ? IDLE : DRAIN;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clke or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_koef  <= '0;
            r_en    <= 1'b0;
            r_arst  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            r_derr  <= 1'b0;
`ifdef KOEF_CHECKSUM_EN
            r_xor   <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_hi    <= w_hi;
            r_koef  <= w_koef;
            r_en    <= w_en;
            r_arst  <= w_arst;
            r_done  <= w_done;
            r_err   <= w_err;
            r_ready <= w_ready;
            r_derr  <= w_derr;
`ifdef KOEF_CHECKSUM_EN
            r_xor   <= w_xor;
`endif
        end
    end

    assign bus.KOEF_OUT      = r_koef;
    assign bus.koef_en_out   = r_en;
    assign bus.koef_addr_rst = r_arst;
    assign bus.load_done     = r_done;
    assign bus.load_err      = r_err;
    assign bus.koef_ready    = r_ready;
    assign bus.busy          = r_state != IDLE;
endmodule

// File: tb/tb_opora_koef_loader.sv
// tb_opora_koef_loader: directed frames with a queue scoreboard for RAM writes and status pulses.
module tb_opora_koef_loader;
    typedef struct {logic [15:0] d; int c;} wexp_t;

    logic clke = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    wexp_t      wq[$];
    logic [2:0] evq[$];
    logic [7:0] fr[$];

    opora_koef_loader_if bus();
    opora_koef_loader dut (.clke(clke), .rst_n(rst_n), .bus(bus.slave));

    always #5 clke = ~clke;
    always @(posedge clke) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Event code per cycle: {koef_addr_rst, load_done, load_err}
    always @(negedge clke) begin
        if (rst_n) begin
            if (bus.koef_en_out) begin
                if (wq.size() == 0) chk("unexpected_write", int'(bus.KOEF_OUT), -1);
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("koef_out", int'(bus.KOEF_OUT), int'(e.d));
                    chk("write_cycle", cyc, e.c);
                end
            end
            if ({bus.koef_addr_rst, bus.load_done, bus.load_err} != 3'b000) begin
                if (evq.size() == 0) chk("unexpected_event", int'({bus.koef_addr_rst, bus.load_done, bus.load_err}), 0);
                else chk("event", int'({bus.koef_addr_rst, bus.load_done, bus.load_err}), int'(evq.pop_front()));
            end
        end
    end

    task automatic build_full();
        fr.delete();
        fr.push_back(8'hC3);
        for (int i = 1; i <= 50; i++) begin
            fr.push_back(8'h00);
            fr.push_back(8'(i));
        end
`ifdef KOEF_CHECKSUM_EN
        fr.push_back(8'h33);
`endif
    endtask

    task automatic push_words(input int n, input int base, input int t0, input int m);
        for (int i = 1; i <= n; i++) wq.push_back('{16'(i), t0 + m * (base + 2 * i) + 1});
    endtask

    task automatic send(input int m, input int sa, input int sb, input int ea);
        for (int i = 0; i < fr.size(); i++) begin
            @(posedge clke); #1;
            bus.eth_valid = 1'b1;
            bus.eth_data  = fr[i];
            bus.eth_sof   = (i == sa) || (i == sb);
            bus.eth_eof   = (i == ea);
            if (m == 2) begin
                @(posedge clke); #1;
                bus.eth_valid = 1'b0;
                bus.eth_sof   = 1'b0;
                bus.eth_eof   = 1'b0;
            end
        end
        @(posedge clke); #1;
        bus.eth_valid = 1'b0;
        bus.eth_sof   = 1'b0;
        bus.eth_eof   = 1'b0;
    endtask

    task automatic settle(input string nm);
        repeat (4) @(posedge clke);
        #1;
        chk({nm, "_writes_left"}, wq.size(), 0);
        chk({nm, "_events_left"}, evq.size(), 0);
    endtask

    task automatic full_frame(input int m, input string nm);
        int t0;
        build_full();
        t0 = cyc + 1;
        evq.push_back(3'b100);
        push_words(50, 0, t0, m);
        evq.push_back(3'b010);
        send(m, 0, -1, fr.size() - 1);
        settle(nm);
        chk({nm, "_ready"}, bus.koef_ready, 1);
        chk({nm, "_busy"}, bus.busy, 0);
    endtask

    task automatic zero_outputs(input string nm);
        chk({nm, "_koef_out"}, int'(bus.KOEF_OUT), 0);
        chk({nm, "_en"}, bus.koef_en_out, 0);
        chk({nm, "_addr_rst"}, bus.koef_addr_rst, 0);
        chk({nm, "_done"}, bus.load_done, 0);
        chk({nm, "_err"}, bus.load_err, 0);
        chk({nm, "_ready"}, bus.koef_ready, 0);
        chk({nm, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        bus.eth_valid = 1'b0;
        bus.eth_sof   = 1'b0;
        bus.eth_eof   = 1'b0;
        bus.eth_data  = 8'h00;
        repeat (3) @(posedge clke);
        #1;
        zero_outputs("reset");
        rst_n = 1'b1;

        full_frame(1, "full");
        full_frame(2, "gapped");

        // Bad header keeps the previous koef_ready and stays busy until eof
        fr = '{8'hA5, 8'h11, 8'h22, 8'h33};
        send(1, 0, -1, -1);
        chk("badhdr_busy", bus.busy, 1);
        chk("badhdr_ready_kept", bus.koef_ready, 1);
        fr = '{8'h44};
        send(1, -1, -1, 0);
        settle("badhdr");
        chk("badhdr_busy_after", bus.busy, 0);
        chk("badhdr_ready_after", bus.koef_ready, 1);

        // Short frame: eof on byte 60 leaves 29 complete words
        build_full();
        while (fr.size() > 60) void'(fr.pop_back());
        t0 = cyc + 1;
        evq.push_back(3'b100);
        push_words(29, 0, t0, 1);
        evq.push_back(3'b001);
        send(1, 0, -1, 59);
        settle("short");
        chk("short_ready", bus.koef_ready, 0);
        chk("short_busy", bus.busy, 0);

        // Abort: sof on byte 40 restarts with a complete frame
        build_full();
        while (fr.size() > 39) void'(fr.pop_back());
        begin
            logic [7:0] part[$];
            part = fr;
            build_full();
            fr = {part, fr};
        end
        t0 = cyc + 1;
        evq.push_back(3'b100);
        push_words(19, 0, t0, 1);
        evq.push_back(3'b101);
        push_words(50, 39, t0, 1);
        evq.push_back(3'b010);
        send(1, 0, 39, fr.size() - 1);
        settle("abort");
        chk("abort_ready", bus.koef_ready, 1);

        // One-byte frame with a good header
        fr = '{8'hC3};
        evq.push_back(3'b101);
        send(1, 0, -1, 0);
        settle("onebyte");
        chk("onebyte_ready", bus.koef_ready, 0);
        chk("onebyte_busy", bus.busy, 0);

        // Long frame: error on the final expected byte, then drain to eof
        build_full();
        fr.push_back(8'hAA);
        fr.push_back(8'hBB);
        fr.push_back(8'hCC);
        t0 = cyc + 1;
        evq.push_back(3'b100);
        push_words(50, 0, t0, 1);
        evq.push_back(3'b001);
        send(1, 0, -1, fr.size() - 1);
        settle("long");
        chk("long_ready", bus.koef_ready, 0);
        chk("long_busy", bus.busy, 0);

`ifdef KOEF_CHECKSUM_EN
        build_full();
        fr[fr.size() - 1] = 8'h32;
        t0 = cyc + 1;
        evq.push_back(3'b100);
        push_words(50, 0, t0, 1);
        evq.push_back(3'b001);
        send(1, 0, -1, fr.size() - 1);
        settle("badsum");
        chk("badsum_ready", bus.koef_ready, 0);
`endif

        // Reset mid-frame clears everything at once and ignores bytes until sof
        full_frame(1, "prereset");
        fr = '{8'hA5, 8'h01, 8'h02};
        send(1, 0, -1, -1);
        chk("prereset_busy", bus.busy, 1);
        chk("prereset_koef", int'(bus.KOEF_OUT), 16'h0032);
        #3 rst_n = 1'b0;
        #1 zero_outputs("midreset");
        @(posedge clke); #2 rst_n = 1'b1;
        fr = '{8'h00, 8'h05, 8'hC3, 8'h06};
        send(1, -1, -1, 3);
        settle("postreset");
        chk("postreset_busy", bus.busy, 0);
        chk("postreset_ready", bus.koef_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/opora_koef_loader.md
OPORA_KOEF_LOADER -- requirements
Module: opora_koef_loader

Interface
REQ-001 The block SHALL have parameter MULT_N, default 50, meaning the number of 16-bit coefficients per reference frame.
REQ-002 The block SHALL have parameter HDR_BYTE, default 8'hC3, meaning the required first payload byte of a coefficient frame.
REQ-003 The block SHALL have port clke, input, 1 bit: the single clock (Ethernet load clock); all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports eth_valid, eth_sof and eth_eof, each input, 1 bit: byte strobe, first-byte marker and last-byte marker, qualified by eth_valid.
REQ-006 The block SHALL have port eth_data, input, 8 bits: payload byte.
REQ-007 The block SHALL have port koef_addr_rst, output, 1 bit: a one-cycle pulse that realigns the coefficient RAM write address to 0.
REQ-008 The block SHALL have ports koef_en_out, output, 1 bit, and KOEF_OUT, output, 16 bits: a write strobe and a signed coefficient for the coefficient RAM write port.
REQ-009 The block SHALL have ports load_done and load_err, each output, 1 bit: one-cycle frame result pulses.
REQ-010 The block SHALL have ports koef_ready, output, 1 bit (a complete valid set is loaded), and busy, output, 1 bit (a frame is in progress).

Function
REQ-011 FSM states SHALL be IDLE, HDR, MSB, LSB, CHK, DRAIN; only beats with eth_valid=1 advance the FSM, and gaps of any length are allowed.
REQ-012 IDLE: a beat with eth_sof=1 SHALL move to HDR logic in the same beat: a byte equal to HDR_BYTE goes to MSB, pulses koef_addr_rst, and clears koef_ready and the word counter.
REQ-013 In HDR, a sof byte not equal to HDR_BYTE SHALL go to DRAIN with no koef_addr_rst and koef_ready unchanged.
REQ-014 MSB SHALL latch eth_data into the high byte and go to LSB; LSB SHALL form {hi,eth_data} on KOEF_OUT and pulse koef_en_out for one cycle, with latency of one clke after the LSB beat.
REQ-015 The word counter (width $clog2(MULT_N+1)) SHALL increment per written word; after word MULT_N the FSM SHALL go to CHK if KOEF_CHECKSUM_EN is defined, else complete.
REQ-016 Completion (with eth_eof=1 on the final byte) SHALL pulse load_done, set koef_ready and return to IDLE.
REQ-017 eth_eof before the last expected byte (short frame) SHALL pulse load_err and return to IDLE, with koef_ready staying 0.
REQ-018 A final byte without eth_eof (long frame) SHALL pulse load_err and go to DRAIN.
REQ-019 DRAIN SHALL discard bytes until an eth_eof beat and then return to IDLE, with load_err pulsed once per frame only.
REQ-020 eth_sof=1 in any non-IDLE state SHALL abort the current frame with a load_err pulse and be processed as a new frame start in the same beat.
REQ-021 When eth_sof=1 and eth_eof=1 on the same beat (1-byte frame), the header check SHALL apply and the frame SHALL then end as a short-frame error.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 koef_en_out SHALL never pulse more than MULT_N times between two koef_addr_rst pulses.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, counter 0, hi byte 0, and drive 0 on KOEF_OUT, koef_en_out, koef_addr_rst, load_done, load_err, koef_ready and busy.
REQ-025 Reset mid-frame SHALL discard the partial frame; after release, bytes SHALL be ignored until the next eth_sof.

Configuration
REQ-026 Macro KOEF_CHECKSUM_EN defined: one trailing checksum byte SHALL follow the MULT_N words, and it must equal the XOR of all coefficient bytes (header excluded).
REQ-027 On checksum mismatch the block SHALL pulse load_err and leave koef_ready=0 (words are already written); on a match with eth_eof it SHALL behave as REQ-016.
REQ-028 Macro KOEF_CHECKSUM_EN undefined: the CHK state and XOR logic SHALL be absent, and the frame length SHALL be exactly 1+2*MULT_N bytes.

Verification
REQ-029 Scenario: MULT_N=50, macro off, header C3 then words 0001..0032 with eof on byte 101 -> one koef_addr_rst, 50 koef_en_out with KOEF_OUT 0x0001..0x0032, load_done, koef_ready=1.
REQ-030 Scenario: same frame with eth_valid low every other cycle -> identical outputs, with each koef_en_out one cycle after its LSB beat.
REQ-031 Scenario: eof on byte 60 -> 29 writes, then load_err, koef_ready=0, busy=0.
REQ-032 Scenario: header 0xA5 -> no koef_addr_rst and no writes, koef_ready keeps its previous value, busy=1 until eof.
REQ-033 Scenario: sof at byte 40 of a frame, then a valid full frame -> one load_err, then a second koef_addr_rst and 50 writes, then load_done.
REQ-034 Scenario: macro on, correct XOR byte -> load_done; checksum byte flipped by 0x01 -> load_err, koef_ready=0; rst_n low mid-frame -> all outputs 0 immediately.
